// File: rtl/ext_bus_pkg.sv
// ext_bus_pkg
// Shared definitions for the external byte-lane bus sequencer:
//   - state_e     : sequencer FSM states
//   - ADDR_BEATS  : number of address beats (4)
//   - CMD_BEAT    : beat number carrying the command byte (5)
//   - DATA_BEATS  : number of data beats (4)
//   - CMD_RD/WR   : command encoding driven on the lane during the CMD beat
//   - byteLane()  : picks byte idx (LSB first) out of a 32-bit word
package ext_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_CMD,
    ST_DATA,
    ST_DONE
  } state_e;

  localparam logic [3:0] ADDR_BEATS = 4'd4;
  localparam logic [3:0] CMD_BEAT   = 4'd5;
  localparam logic [3:0] DATA_BEATS = 4'd4;

  localparam logic CMD_RD = 1'b0;
  localparam logic CMD_WR = 1'b1;

  function automatic logic [7:0] byteLane(input logic [31:0] word, input logic [1:0] idx);
    byteLane = word[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/ext_bus_arbiter.sv
// ext_bus_arbiter
// Purely combinational two-requester grant selection.
// Ports:
//   req0_i, req1_i : request from requester 0 / 1
//   lastGrant_i    : 1 = requester 1 was granted last (only with ARB_ROUND_ROBIN_EN)
//   grant_o[1:0]   : one-hot grant, bit n = requester n; 0 when nobody requests
// Configuration macro: ARB_ROUND_ROBIN_EN
//   defined   -> on a simultaneous request the requester not granted last wins
//   undefined -> requester 0 always wins a simultaneous request
module ext_bus_arbiter (
  input  logic       req0_i,
  input  logic       req1_i,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic       lastGrant_i,
`endif
  output logic [1:0] grant_o
);

  // Single requests are granted directly; only the tie case depends on the policy.
  always_comb begin
    grant_o = 2'b00;
    if (req0_i && req1_i) begin
`ifdef ARB_ROUND_ROBIN_EN
      grant_o = lastGrant_i ? 2'b01 : 2'b10;
`else
      grant_o = 2'b01;
`endif
    end else if (req0_i) begin
      grant_o = 2'b01;
    end else if (req1_i) begin
      grant_o = 2'b10;
    end
  end

endmodule

// File: rtl/ext_bus_sequencer.sv
// ext_bus_sequencer
// Serialises one transaction at a time from two requesters onto an 8-bit
// external lane: 4 address beats (LSB first), 1 command beat, 4 data beats,
// then a one-cycle DONE that pulses the winner's ack.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   req0/req1         : transaction requests
//   we0/we1           : 1 = write, 0 = read
//   addr0/addr1       : transaction addresses
//   wdata0/wdata1     : write data
//   ack0/ack1         : one-cycle completion pulses
//   rdata             : read data, valid while an ack is high, held otherwise
//   bus_out/bus_in    : external byte lane out / in
//   bus_oe            : 1 = block drives the lane
//   phase             : beat number, 0 = idle/done, 1..9 = active beat
// Configuration macro: ARB_ROUND_ROBIN_EN (round-robin tie breaking and the
// last-grant pointer; absent -> fixed priority to requester 0).
module ext_bus_sequencer
  import ext_bus_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic [7:0]        bus_out,
  input  logic [7:0]        bus_in,
  output logic              bus_oe,
  output logic [3:0]        phase
);

  state_e              state_q, state_d;
  logic [3:0]          beat_q, beat_d;
  logic                txnId_q, txnId_d;
  logic                txnWe_q, txnWe_d;
  logic [ADDR_W-1:0]   txnAddr_q, txnAddr_d;
  logic [DATA_W-1:0]   txnData_q, txnData_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [7:0]          busOut_q, busOut_d;
  logic                busOe_q, busOe_d;
  logic [3:0]          phase_q, phase_d;
  logic                ack0_q, ack0_d;
  logic                ack1_q, ack1_d;
  logic [1:0]          grant;
`ifdef ARB_ROUND_ROBIN_EN
  logic                lastGrant_q, lastGrant_d;
`endif

  ext_bus_arbiter u_arbiter (
    .req0_i      (req0),
    .req1_i      (req1),
`ifdef ARB_ROUND_ROBIN_EN
    .lastGrant_i (lastGrant_q),
`endif
    .grant_o     (grant)
  );

  // Next-state logic. Requests are only looked at in IDLE; the winner's
  // command is latched there and everything afterwards runs from the latch.
  // Outputs are derived from the *next* state and latched transaction so
  // that, once registered, they line up with the state they describe.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    txnId_d   = txnId_q;
    txnWe_d   = txnWe_q;
    txnAddr_d = txnAddr_q;
    txnData_d = txnData_q;
    rdata_d   = rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
    lastGrant_d = lastGrant_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (grant != 2'b00) begin
          state_d   = ST_ADDR;
          beat_d    = 4'd0;
          txnId_d   = grant[1];
          txnWe_d   = grant[1] ? we1 : we0;
          txnAddr_d = grant[1] ? addr1 : addr0;
          txnData_d = grant[1] ? wdata1 : wdata0;
`ifdef ARB_ROUND_ROBIN_EN
          lastGrant_d = grant[1];
`endif
        end
      end
      ST_ADDR: begin
        if (beat_q == ADDR_BEATS - 4'd1) begin
          state_d = ST_CMD;
          beat_d  = 4'd0;
        end else begin
          beat_d = beat_q + 4'd1;
        end
      end
      ST_CMD: begin
        state_d = ST_DATA;
        beat_d  = 4'd0;
      end
      ST_DATA: begin
        // Read data is sampled at the end of each data beat.
        if (txnWe_q == CMD_RD) begin
          rdata_d[{beat_q[1:0], 3'b000} +: 8] = bus_in;
        end
        if (beat_q == DATA_BEATS - 4'd1) begin
          state_d = ST_DONE;
          beat_d  = 4'd0;
        end else begin
          beat_d = beat_q + 4'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    phase_d  = 4'd0;
    busOut_d = 8'h00;
    busOe_d  = 1'b0;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;

    case (state_d)
      ST_ADDR: begin
        phase_d  = beat_d + 4'd1;
        busOut_d = byteLane(txnAddr_d, beat_d[1:0]);
        busOe_d  = 1'b1;
      end
      ST_CMD: begin
        phase_d  = CMD_BEAT;
        busOut_d = {7'b0, txnWe_d};
        busOe_d  = 1'b1;
      end
      ST_DATA: begin
        phase_d = CMD_BEAT + 4'd1 + beat_d;
        if (txnWe_d == CMD_WR) begin
          busOut_d = byteLane(txnData_d, beat_d[1:0]);
          busOe_d  = 1'b1;
        end
      end
      ST_DONE: begin
        ack0_d = ~txnId_d;
        ack1_d = txnId_d;
      end
      default: begin
      end
    endcase
  end

  // State, transaction latch and registered outputs. Reset is immediate and
  // drops any transaction in flight without acknowledging it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      beat_q    <= 4'd0;
      txnId_q   <= 1'b0;
      txnWe_q   <= 1'b0;
      txnAddr_q <= '0;
      txnData_q <= '0;
      rdata_q   <= '0;
      busOut_q  <= 8'h00;
      busOe_q   <= 1'b0;
      phase_q   <= 4'd0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      lastGrant_q <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      txnId_q   <= txnId_d;
      txnWe_q   <= txnWe_d;
      txnAddr_q <= txnAddr_d;
      txnData_q <= txnData_d;
      rdata_q   <= rdata_d;
      busOut_q  <= busOut_d;
      busOe_q   <= busOe_d;
      phase_q   <= phase_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
`ifdef ARB_ROUND_ROBIN_EN
      lastGrant_q <= lastGrant_d;
`endif
    end
  end

  assign ack0    = ack0_q;
  assign ack1    = ack1_q;
  assign rdata   = rdata_q;
  assign bus_out = busOut_q;
  assign bus_oe  = busOe_q;
  assign phase   = phase_q;

endmodule

// File: doc/ext_bus_sequencer.md
EXT_BUS_SEQUENCER -- requirements
Module: ext_bus_sequencer

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning the requester address width; only 32 is supported.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the requester data width; only 32 is supported.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-high: clk input 1, rising-edge clock.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 req0, req1  input  1 each  transaction request from requester 0 and requester 1.
REQ-006 we0, we1  input  1 each  1 = write, 0 = read.
REQ-007 addr0, addr1  input  32 each  transaction address.
REQ-008 wdata0, wdata1  input  32 each  write data.
REQ-009 ack0, ack1  output  1 each  one-cycle completion pulse.
REQ-010 rdata  output  32  read data, valid while an ack is high.
REQ-011 bus_out  output  8  external byte lane.
REQ-012 bus_in  input  8  external byte lane.
REQ-013 bus_oe  output  1  1 = block drives the pad lane.
REQ-014 phase  output  4  current beat number: 0 = idle, 1..9 = active beat.

Function
REQ-015 The FSM SHALL have the states IDLE, ADDR (beats 1-4), CMD (beat 5), DATA (beats 6-9) and DONE.
REQ-016 In IDLE with any request high, the FSM SHALL latch the winner's we, addr and wdata and enter ADDR on the next edge; requester inputs are ignored from then until IDLE is re-entered.
REQ-017 ADDR beat k (k = 0..3) SHALL drive bus_out = addr[8k+7:8k] with bus_oe = 1, least-significant byte first.
REQ-018 CMD SHALL drive bus_out = {7'b0, we} with bus_oe = 1.
REQ-019 On a write, DATA beat k SHALL drive bus_out = wdata[8k+7:8k] with bus_oe = 1.
REQ-020 On a read, DATA beat k SHALL drive bus_oe = 0 and bus_out = 0, and SHALL capture bus_in into rdata[8k+7:8k] at the end of the beat.
REQ-021 DONE SHALL last exactly one cycle, assert the winner's ack, and return to IDLE.
REQ-022 Latency SHALL be 10 cycles from the request being sampled in IDLE to the ack edge; back-to-back transactions SHALL have one IDLE cycle between them.
REQ-023 All outputs SHALL be registered; phase SHALL equal the beat number (1..9), and 0 in IDLE and DONE.
REQ-024 rdata SHALL hold its last value after a read and SHALL be unchanged by writes.
REQ-025 A request dropped mid-transaction SHALL NOT abort the transaction; the ack is still issued.
REQ-026 A request still high at DONE SHALL be re-arbitrated in the following IDLE cycle.
REQ-027 ack0 and ack1 SHALL never be high in the same cycle.

Reset
REQ-028 Reset SHALL take effect immediately, including mid-transaction: state IDLE, phase 0, bus_out 0, bus_oe 0, ack0/ack1 0, rdata 0, last-grant pointer pointing at requester 1 (so requester 0 wins first); no ack is issued for an aborted transaction.

Configuration
REQ-029 With ARB_ROUND_ROBIN_EN defined, when both requests are high the requester not granted last SHALL win.
REQ-030 Without ARB_ROUND_ROBIN_EN, requester 0 SHALL always win a simultaneous request, and the last-grant pointer SHALL be absent.

Structure
REQ-031 Package ext_bus_pkg SHALL hold the state enum, the beat constants (ADDR_BEATS = 4, CMD_BEAT = 5, DATA_BEATS = 4) and the command encoding (CMD_RD = 0, CMD_WR = 1).
REQ-032 Grant selection SHALL be a sub-module ext_bus_arbiter: inputs req0, req1 and the last-grant pointer; output a one-hot grant; purely combinational; it holds the macro logic.

Verification
REQ-033 Write from requester 0 (addr0 = 0x12345678, wdata0 = 0xA1B2C3D4) -> bus_out 78,56,34,12,01,D4,C3,B2,A1 on phases 1-9, bus_oe = 1 throughout, ack0 at cycle 10.
REQ-034 Read from requester 1 (addr1 = 0x00000010), bus_in 0x11,0x22,0x33,0x44 in phases 6-9 -> bus_oe = 0 in phases 6-9, rdata = 0x44332211 with ack1.
REQ-035 req0 and req1 both held high for 3 transactions with ARB_ROUND_ROBIN_EN -> grants 0,1,0; without the macro -> grants 0,0,0.
REQ-036 rst pulsed during phase 7 of a write -> all outputs 0 in the same cycle, no ack, and a fresh request afterwards completes normally.
REQ-037 req0 dropped at phase 3 -> the transaction completes and ack0 pulses at cycle 10; no second transaction starts.
